// File: rtl/ex_redirect_unit_pkg.sv
// Shared encodings for the EX-stage redirect unit: branch types, FSM states, data width.
package ex_redirect_unit_pkg;

    localparam int unsigned XLEN = 32;

    // ex_br_type encoding; type 7 is split into BLTU/BGEU by funct_u
    typedef enum logic [2:0] {
        BR_NONE     = 3'd0,
        BR_JAL      = 3'd1,
        BR_JALR     = 3'd2,
        BR_BEQ      = 3'd3,
        BR_BNE      = 3'd4,
        BR_BLT      = 3'd5,
        BR_BGE      = 3'd6,
        BR_BLTU_GEU = 3'd7
    } br_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

    // JALR clears bit 0 of rs1+imm; everything else is PC-relative
    function automatic logic [XLEN-1:0] calc_target(
        input logic            is_jalr,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] rs1
    );
        logic [XLEN-1:0] sum;
        if (is_jalr) begin
            sum = rs1 + imm;
            return sum & {{(XLEN-1){1'b1}}, 1'b0};
        end
        return pc + imm;
    endfunction

endpackage

// File: rtl/ex_redirect_unit_br_cmp.sv
// Branch condition evaluator: decides whether a control-flow instruction is taken.
module ex_redirect_unit_br_cmp
    import ex_redirect_unit_pkg::*;
(
    input  logic [2:0]      i_br_type,
    input  logic            i_funct_u,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_cond_true
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);

    // Select the comparison for the decoded type; jumps are unconditionally taken
    always_comb begin
        o_cond_true = 1'b0;
        case (br_type_e'(i_br_type))
            BR_JAL, BR_JALR: o_cond_true = 1'b1;
            BR_BEQ:          o_cond_true = w_eq;
            BR_BNE:          o_cond_true = ~w_eq;
            BR_BLT:          o_cond_true = w_lt_s;
            BR_BGE:          o_cond_true = ~w_lt_s;
            BR_BLTU_GEU:     o_cond_true = i_funct_u ? ~w_lt_u : w_lt_u;
            default:         o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_redirect_unit.sv
// EX-stage control-flow resolver: computes branch/jump targets, drives the fetch redirect,
// flushes wrong-path slots, tracks a post-redirect shadow window and counts branches.
module ex_redirect_unit
    import ex_redirect_unit_pkg::*;
#(
    parameter int unsigned SHADOW_CYC = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_stall,
    input  logic [2:0]       i_ex_br_type,
    input  logic             i_ex_funct_u,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [XLEN-1:0]  i_ex_imm,
    input  logic [XLEN-1:0]  i_ex_rs1,
    input  logic [XLEN-1:0]  i_ex_rs2,
    input  logic             i_cnt_clr,
    output logic [XLEN-1:0]  o_ex_npc,
    output logic             o_is_jump,
    output logic [XLEN-1:0]  o_link_addr,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_squash_ex,
    output logic             o_misalign_exc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYC - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_shadow_cnt;
    logic [2:0]        w_shadow_cnt_next;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_cond;
    logic              w_resolve;
    logic              w_is_jalr;
    logic [XLEN-1:0]   w_target;
    logic              w_taken_ok;
    logic              w_taken_bad;

    ex_redirect_unit_br_cmp u_br_cmp (
        .i_br_type   (i_ex_br_type),
        .i_funct_u   (i_ex_funct_u),
        .i_rs1       (i_ex_rs1),
        .i_rs2       (i_ex_rs2),
        .o_cond_true (w_cond)
    );

    assign w_resolve   = i_ex_valid & ~i_ex_stall & (r_state == ST_IDLE)
                       & (i_ex_br_type != 3'd0);
    assign w_is_jalr   = (br_type_e'(i_ex_br_type) == BR_JALR);
    assign w_target    = calc_target(w_is_jalr, i_ex_pc, i_ex_imm, i_ex_rs1);
    // A taken target that is not word aligned traps instead of redirecting
    assign w_taken_ok  = w_resolve & w_cond & ~w_target[1];
    assign w_taken_bad = w_resolve & w_cond & w_target[1];

    // State register: shadow FSM and its countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shadow_cnt <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_shadow_cnt <= w_shadow_cnt_next;
        end
    end

    // Next-state: enter SHADOW on redirect, count down on un-stalled cycles
    always_comb begin
        w_state_next      = r_state;
        w_shadow_cnt_next = r_shadow_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_taken_ok) begin
                    w_state_next      = ST_SHADOW;
                    w_shadow_cnt_next = SHADOW_LOAD;
                end
            end
            ST_SHADOW: begin
                if (!i_ex_stall) begin
                    if (r_shadow_cnt == 3'd0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_shadow_cnt_next = r_shadow_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_next      = ST_IDLE;
                w_shadow_cnt_next = 3'd0;
            end
        endcase
    end

    // Outputs: redirect, flush and squash; everything forced low while in reset
    always_comb begin
        o_ex_npc       = '0;
        o_is_jump      = 1'b0;
        o_link_addr    = '0;
        o_flush_if_id  = 1'b0;
        o_flush_id_ex  = 1'b0;
        o_squash_ex    = 1'b0;
        o_misalign_exc = 1'b0;
        if (rst_n) begin
            o_ex_npc       = w_resolve ? w_target : '0;
            o_is_jump      = w_taken_ok;
            o_link_addr    = i_ex_pc + XLEN'(4);
            o_flush_if_id  = w_taken_ok;
            o_flush_id_ex  = w_taken_ok | (r_state == ST_SHADOW);
            o_squash_ex    = (r_state == ST_SHADOW) & i_ex_valid;
            o_misalign_exc = w_taken_bad;
        end
    end

    // Perf counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else begin
            if (w_resolve) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_taken_ok) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign o_br_cnt    = r_br_cnt;
    assign o_taken_cnt = r_taken_cnt;

endmodule
